// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder: FSM states and the Gray-code
// phase order that defines forward (up) and reverse (down) motion.
package quad_decoder_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Forward motion visits PH0 -> PH1 -> PH2 -> PH3 -> PH0; reverse is the opposite order.
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      default: return PH0;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] s);
    case (s)
      PH0:     return PH3;
      PH3:     return PH2;
      PH2:     return PH1;
      default: return PH0;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder inputs and decoder outputs, plus the FSM state for debug visibility.
interface quad_decoder_if;
  import quad_decoder_pkg::*;

  logic   a_in;
  logic   b_in;
  logic   step;
  logic   dir;
  logic   err;
  state_t state;

  modport master (output a_in, output b_in, input step, input dir, input err, input state);
  modport slave  (input a_in, input b_in, output step, output dir, output err, output state);

endinterface

// File: rtl/sync_debounce.sv
// One encoder channel: two-flop synchronizer, plus a stability filter when
// QUAD_DECODER_DEBOUNCE_EN is defined (otherwise FILTER_CYCLES is ignored).
module sync_debounce #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic valid
);

  logic       sync1_q;
  logic       sync2_q;
  logic [1:0] fill_q;

  // fill_q marks when sync2_q holds a sample taken after reset was released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  // level is meaningful only once valid rises; valid then stays high until reset.
`ifdef QUAD_DECODER_DEBOUNCE_EN
  localparam logic [7:0] FILT = 8'(FILTER_CYCLES);

  logic [7:0] cnt_q;
  logic [7:0] cnt_nxt;
  logic       last_q;
  logic       level_q;
  logic       valid_q;

  // cnt_q is the length of the current run of identical synchronized samples.
  always_comb begin
    cnt_nxt = cnt_q;
    if (cnt_q == 8'd0 || sync2_q != last_q) begin
      cnt_nxt = 8'd1;
    end else if (cnt_q < FILT) begin
      cnt_nxt = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      last_q  <= 1'b0;
      level_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (fill_q[1]) begin
      last_q <= sync2_q;
      cnt_q  <= cnt_nxt;
      if (cnt_nxt == FILT) begin
        level_q <= sync2_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign level = level_q;
  assign valid = valid_q;
`else
  wire [31:0] unused_filter = FILTER_CYCLES;

  assign level = sync2_q;
  assign valid = fill_q[1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: turns encoder A/B edges into step/dir pulses and flags
// two-bit jumps on err. Optional input filter via QUAD_DECODER_DEBOUNCE_EN.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  quad_decoder_if.slave bus
);

  logic a_lvl;
  logic b_lvl;
  logic a_vld;
  logic b_vld;

  sync_debounce #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.a_in),
    .level (a_lvl),
    .valid (a_vld)
  );

  sync_debounce #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.b_in),
    .level (b_lvl),
    .valid (b_vld)
  );

  wire [1:0] cur       = {a_lvl, b_lvl};
  wire       sample_ok = a_vld & b_vld;

  state_t     state_q;
  logic [1:0] prev_q;
  logic       step_q;
  logic       err_q;
  logic       dir_q;
  logic       step_nxt;
  logic       err_nxt;
  logic       dir_nxt;

  always_comb begin
    step_nxt = 1'b0;
    err_nxt  = 1'b0;
    dir_nxt  = dir_q;
    if (state_q == ST_RUN && cur != prev_q) begin
      if (cur == fwd_next(prev_q)) begin
        step_nxt = 1'b1;
        dir_nxt  = 1'b1;
      end else if (cur == rev_next(prev_q)) begin
        step_nxt = 1'b1;
        dir_nxt  = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  // INIT waits for the first post-reset sample so stale pre-reset edges never step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      prev_q  <= 2'b00;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      step_q <= step_nxt;
      err_q  <= err_nxt;
      dir_q  <= dir_nxt;
      case (state_q)
        ST_INIT: begin
          if (sample_ok) begin
            prev_q  <= cur;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: prev_q <= cur;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign bus.step  = step_q;
  assign bus.err   = err_q;
  assign bus.dir   = dir_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: a phase-position model predicts each
// step/err event and its cycle; a monitor pops and compares on every pulse.
module tb_quad_decoder;
  import quad_decoder_pkg::*;

  localparam int F = 4;
`ifdef QUAD_DECODER_DEBOUNCE_EN
  localparam int LAT      = 3 + F;
  localparam int HOLD_MIN = F + 1;
`else
  localparam int LAT      = 3;
  localparam int HOLD_MIN = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  quad_decoder_if bus();

  quad_decoder #(.FILTER_CYCLES(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // scoreboard: {expected cycle, err, dir}
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [33:0] exp_q[$];

  // model: position 0..3 along the forward Gray sequence, plus held direction
  logic [1:0] gray[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int         pos_m   = 0;
  logic       dir_m   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic int pos_of(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (gray[i] == v) return i;
    return 0;
  endfunction

  // driver: called on a falling edge, drives {a,b} and holds it for `hold` cycles
  task automatic drive_ab(input logic [1:0] v, input int hold);
    int d;
    d = (pos_of(v) - pos_m + 4) % 4;
    bus.a_in = v[1];
    bus.b_in = v[0];
    if (d == 1) begin
      dir_m = 1'b1;
      exp_q.push_back({32'(cyc + LAT), 1'b0, 1'b1});
    end else if (d == 3) begin
      dir_m = 1'b0;
      exp_q.push_back({32'(cyc + LAT), 1'b0, 1'b0});
    end else if (d == 2) begin
      exp_q.push_back({32'(cyc + LAT), 1'b1, dir_m});
    end
    pos_m = pos_of(v);
    repeat (hold) @(negedge clk);
  endtask

  // one-cycle reset from a falling edge; ends on a falling edge with the FSM in RUN
  task automatic do_reset();
    int n;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("reset_step", 32'(bus.step), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_dir", 32'(bus.dir), 32'd1);
    check("reset_state", 32'(bus.state), 32'(ST_INIT));
    @(negedge clk);
    rst   = 1'b0;
    pos_m = pos_of({bus.a_in, bus.b_in});
    dir_m = 1'b1;
    n = 0;
    while (bus.state != ST_RUN && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("init_to_run", 32'(bus.state == ST_RUN), 32'd1);
  endtask

  // monitor
  logic last_dir = 1'b1;
  always @(posedge clk) begin
    logic [33:0] e;
    #1;
    if (rst) begin
      last_dir = bus.dir;
    end else begin
      if (bus.step && bus.err) check("step_err_exclusive", 32'd1, 32'd0);
      if (bus.step || bus.err) begin
        if (exp_q.size() == 0) begin
          check("spurious_event", 32'({bus.step, bus.err}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", 32'(cyc), e[33:2]);
          check("event_err", 32'(bus.err), 32'(e[1]));
          check("event_dir", 32'(bus.dir), 32'(e[0]));
        end
      end
      if (bus.dir != last_dir) check("dir_only_with_step", 32'(bus.step), 32'd1);
      last_dir = bus.dir;
    end
  end

  // stimulus
  initial begin
    int n;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    @(negedge clk);
    do_reset();

    // idle after reset: no pulses, dir stays up
    for (int i = 0; i < 10; i++) begin
      check("idle_step", 32'(bus.step), 32'd0);
      check("idle_err", 32'(bus.err), 32'd0);
      check("idle_dir", 32'(bus.dir), 32'd1);
      @(negedge clk);
    end

    // forward then reverse full cycles
    drive_ab(2'b10, 20);
    drive_ab(2'b11, 20);
    drive_ab(2'b01, 20);
    drive_ab(2'b00, 20);
    drive_ab(2'b01, 20);
    drive_ab(2'b11, 20);
    drive_ab(2'b10, 20);
    drive_ab(2'b00, 20);

    // illegal jump, then legal forward step
    drive_ab(2'b11, 20);
    drive_ab(2'b01, 20);
    drive_ab(2'b00, 20);

    // reset one cycle after an edge discards that edge
    bus.a_in = 1'b1;
    bus.b_in = 1'b0;
    @(negedge clk);
    do_reset();
    drive_ab(2'b10, 10);
    drive_ab(2'b00, 20);

`ifdef QUAD_DECODER_DEBOUNCE_EN
    // short glitch is filtered, a longer hold is accepted
    bus.a_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.a_in = 1'b0;
    repeat (12) @(negedge clk);
    drive_ab(2'b10, 6);
    drive_ab(2'b00, 20);
`endif

    // randomized walk: same, forward, reverse and two-bit jumps
    for (int i = 0; i < 200; i++) begin
      drive_ab(gray[$urandom_range(0, 3)], $urandom_range(HOLD_MIN, HOLD_MIN + 3));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
